// File: rtl/mux_scan_seq.sv
// Registered N:1 channel mux with a one-shot sweep sequencer; din to dout latency 1 clk.
// Output register reloads only when empty or accepted, so a stalled beat holds every field.
module mux_scan_seq #(
  parameter int N_CH  = 16,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] din,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic              start,
  input  logic              force_hi,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [W-1:0]      dout,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_last,
  output logic              sel_err,
  output logic              busy
);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_X  = (SEL_W + 1)'(N_CH);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   scan_ptr_q, scan_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       dout_q, dout_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_last_q, out_last_d;
  logic               sel_err_q, sel_err_d;

  logic               slot_open;
  logic               load;
  logic [SEL_W-1:0]   load_ch;
  logic               load_last;
  logic               load_err;

  // Out-of-range indices fall through to zero rather than reading past din.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] bus,
                                        input logic [SEL_W-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r = bus[k*W +: W];
    end
    return r;
  endfunction

  always_comb begin
    slot_open   = !out_valid_q || out_ready;
    load        = 1'b0;
    load_ch     = sel_in;
    load_last   = 1'b0;
    load_err    = 1'b0;
    state_d     = state_q;
    scan_ptr_d  = scan_ptr_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    sel_err_d   = sel_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!mode) begin
          load     = slot_open;
          load_ch  = sel_in;
          load_err = ({1'b0, sel_in} >= N_CH_X);
        end else if (start) begin
          state_d    = ST_SCAN;
          scan_ptr_d = '0;
        end
      end
      ST_SCAN: begin
        load_ch   = scan_ptr_q;
        load_last = (scan_ptr_q == LAST_CH);
        if (slot_open) begin
          load = 1'b1;
          if (load_last) begin
            state_d    = ST_IDLE;
            scan_ptr_d = '0;
          end else begin
            scan_ptr_d = scan_ptr_q + SEL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      dout_d      = force_hi ? '1 : (load_err ? '0 : pick(din, load_ch));
      out_ch_d    = load_ch;
      out_last_d  = load_last;
      sel_err_d   = load_err;
    end else if (slot_open) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scan_ptr_q  <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_ptr_q  <= scan_ptr_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign sel_err   = sel_err_q;
  assign busy      = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: a 16-channel and a 10-channel instance, each checked against
// an ordered queue of expected beats plus hand-computed literals.
module tb_mux_scan_seq;

  localparam int N0 = 16;
  localparam int N1 = 10;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [N0*W-1:0] din0;
  logic            mode0, start0, force0, rdy0;
  logic [3:0]      sel0;
  logic            vld0, last0, err0, busy0;
  logic [W-1:0]    dout0;
  logic [3:0]      ch0;

  logic [N1*W-1:0] din1;
  logic            mode1, start1, force1, rdy1;
  logic [3:0]      sel1;
  logic            vld1, last1, err1, busy1;
  logic [W-1:0]    dout1;
  logic [3:0]      ch1;

  mux_scan_seq #(.N_CH(N0), .W(W)) u_dut0 (
    .clk(clk), .rst(rst), .din(din0), .mode(mode0), .sel_in(sel0), .start(start0),
    .force_hi(force0), .out_ready(rdy0), .out_valid(vld0), .dout(dout0), .out_ch(ch0),
    .out_last(last0), .sel_err(err0), .busy(busy0)
  );

  mux_scan_seq #(.N_CH(N1), .W(W)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .mode(mode1), .sel_in(sel1), .start(start1),
    .force_hi(force1), .out_ready(rdy1), .out_valid(vld1), .dout(dout1), .out_ch(ch1),
    .out_last(last1), .sel_err(err1), .busy(busy1)
  );

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] dat;
    logic       last;
    logic       err;
  } beat_t;

  logic [7:0] val0 [N0];
  logic [7:0] val1 [N1];
  beat_t      q0[$];
  beat_t      q1[$];
  beat_t      held [2];
  bit         stall_prev [2];
  int         checks = 0;
  int         errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beat straight from the channel tables and the selection rules.
  function automatic beat_t mk(input int id, input int ch, input bit f, input bit scan);
    int    n = (id == 0) ? N0 : N1;
    beat_t b;
    b.ch   = ch[3:0];
    b.last = scan && (ch == n - 1);
    b.err  = (ch >= n);
    if (f)            b.dat = 8'hFF;
    else if (ch >= n) b.dat = 8'h00;
    else              b.dat = (id == 0) ? val0[ch] : val1[ch];
    return b;
  endfunction

  task automatic push_scan(input int id, input bit f3, input bit f4);
    int n = (id == 0) ? N0 : N1;
    for (int k = 0; k < n; k++) begin
      if (id == 0) q0.push_back(mk(0, k, (k == 3 && f3) || (k == 4 && f4), 1'b1));
      else         q1.push_back(mk(1, k, 1'b0, 1'b1));
    end
  endtask

  task automatic pack_din;
    for (int k = 0; k < N0; k++) din0[k*W +: W] = val0[k];
    for (int k = 0; k < N1; k++) din1[k*W +: W] = val1[k];
  endtask

  task automatic mon(input int id, input logic v, input logic r, input beat_t cur);
    beat_t e;
    int    qs;
    if (rst) begin
      if (id == 0) q0.delete(); else q1.delete();
      stall_prev[id] = 1'b0;
      return;
    end
    if (stall_prev[id]) begin
      cmp($sformatf("hold_vld%0d", id), 32'(v), 32'd1);
      if (v) cmp($sformatf("hold_beat%0d", id), 32'(cur), 32'(held[id]));
    end
    if (v && r) begin
      qs = (id == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat%0d: got ch %0d expected no beat", id, cur.ch);
      end else begin
        if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
        cmp($sformatf("beat%0d_ch%0d", id, e.ch), 32'(cur), 32'(e));
      end
    end
    stall_prev[id] = v && !r;
    held[id]       = cur;
  endtask

  always @(negedge clk) begin
    mon(0, vld0, rdy0, {ch0, dout0, last0, err0});
    mon(1, vld1, rdy1, {ch1, dout1, last1, err1});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int id, input int budget);
    for (int i = 0; i < budget && ((id == 0) ? q0.size() : q1.size()) > 0; i++) tick();
    cmp($sformatf("drain%0d", id), (id == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mode0 = 1'b1; start0 = 1'b0; force0 = 1'b0; rdy0 = 1'b1; sel0 = '0;
    mode1 = 1'b1; start1 = 1'b0; force1 = 1'b0; rdy1 = 1'b1; sel1 = '0;
    for (int k = 0; k < N0; k++) val0[k] = 8'(k * 3);
    for (int k = 0; k < N1; k++) val1[k] = 8'(8'h40 + k);
    pack_din();
    tick(); tick();
    cmp("rst_vld0", vld0, 0);  cmp("rst_dout0", dout0, 0); cmp("rst_ch0", ch0, 0);
    cmp("rst_last0", last0, 0); cmp("rst_err0", err0, 0);  cmp("rst_busy0", busy0, 0);
    cmp("rst_vld1", vld1, 0);  cmp("rst_busy1", busy1, 0);
    rst = 1'b0;

    // DIRECT on the 16-channel instance, including a stall with inputs wiggling.
    mode0 = 1'b0;
    sel0 = 4'd5;  q0.push_back(mk(0, 5, 1'b0, 1'b0));  tick();
    cmp("direct_dout5", dout0, 15); cmp("direct_ch5", ch0, 5); cmp("direct_vld", vld0, 1);
    sel0 = 4'd0;  q0.push_back(mk(0, 0, 1'b0, 1'b0));  tick();
    sel0 = 4'd11; q0.push_back(mk(0, 11, 1'b0, 1'b0)); tick();
    cmp("direct_dout11", dout0, 33);
    rdy0 = 1'b0; sel0 = 4'd7; force0 = 1'b1;
    tick(); tick();
    cmp("stall_dout", dout0, 33); cmp("stall_ch", ch0, 11);
    rdy0 = 1'b1; force0 = 1'b0; q0.push_back(mk(0, 7, 1'b0, 1'b0)); tick();
    cmp("direct_dout7", dout0, 21);
    sel0 = 4'd2; force0 = 1'b1; q0.push_back(mk(0, 2, 1'b1, 1'b0)); tick();
    cmp("force_dout", dout0, 8'hFF); cmp("force_ch", ch0, 2);
    force0 = 1'b0; mode0 = 1'b1; tick();
    cmp("idle_consumed", vld0, 0);

    // Full sweep with a free-running consumer; mode/start noise mid-sweep is ignored.
    start0 = 1'b1; push_scan(0, 1'b0, 1'b0); tick(); start0 = 1'b0;
    cmp("scan_busy", busy0, 1); cmp("scan_no_beat_yet", vld0, 0);
    for (int k = 0; k < N0; k++) begin
      if (k == 5) begin mode0 = 1'b0; sel0 = 4'd3; start0 = 1'b1; end
      if (k == 8) begin mode0 = 1'b1; start0 = 1'b0; end
      tick();
      cmp($sformatf("scan_ch%0d", k), ch0, k);
      cmp($sformatf("scan_last%0d", k), last0, (k == N0 - 1) ? 1 : 0);
      cmp($sformatf("scan_busy%0d", k), busy0, (k == N0 - 1) ? 0 : 1);
    end
    tick();
    cmp("scan_done_vld", vld0, 0);
    drain(0, 5);

    // Sweep under a 1,0,0 ready pattern with force_hi toggled only while stalled.
    for (int k = 0; k < N0; k++) val0[k] = 8'hF0 ^ 8'(k * 17);
    pack_din();
    start0 = 1'b1; push_scan(0, 1'b0, 1'b0); tick(); start0 = 1'b0;
    for (int i = 0; i < 200 && q0.size() > 0; i++) begin
      rdy0   = (i % 3 == 0);
      force0 = (i > 0) && !rdy0;
      tick();
    end
    rdy0 = 1'b1; force0 = 1'b0;
    tick(); tick();
    cmp("stall_sweep_left", q0.size(), 0);
    cmp("stall_sweep_vld", vld0, 0);

    // force_hi on the loads of channels 3 and 4 only.
    start0 = 1'b1; push_scan(0, 1'b1, 1'b1); tick(); start0 = 1'b0;
    for (int k = 0; k < N0; k++) begin
      force0 = (k == 3 || k == 4);
      tick();
      if (k == 3) begin cmp("f3_dout", dout0, 8'hFF); cmp("f3_ch", ch0, 3); end
      if (k == 5) cmp("f5_dout", dout0, 8'hA5);
    end
    force0 = 1'b0;
    tick();
    drain(0, 5);

    // Reset mid-sweep, then a fresh sweep restarts from channel 0.
    start0 = 1'b1; push_scan(0, 1'b0, 1'b0); tick(); start0 = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    cmp("pre_rst_ch", ch0, 7);
    rst = 1'b1; tick();
    cmp("rst_mid_vld", vld0, 0); cmp("rst_mid_busy", busy0, 0);
    cmp("rst_mid_last", last0, 0); cmp("rst_mid_ch", ch0, 0);
    rst = 1'b0;
    start0 = 1'b1; push_scan(0, 1'b0, 1'b0); tick(); start0 = 1'b0;
    tick();
    cmp("restart_ch", ch0, 0); cmp("restart_vld", vld0, 1);
    drain(0, 40);

    // 10-channel instance: out-of-range selects and a sweep that stops at 9.
    mode1 = 1'b0;
    sel1 = 4'd12; q1.push_back(mk(1, 12, 1'b0, 1'b0)); tick();
    cmp("n10_dout12", dout1, 0); cmp("n10_err12", err1, 1);
    sel1 = 4'd9;  q1.push_back(mk(1, 9, 1'b0, 1'b0));  tick();
    cmp("n10_err9", err1, 0); cmp("n10_dout9", dout1, 8'h49);
    sel1 = 4'd15; force1 = 1'b1; q1.push_back(mk(1, 15, 1'b1, 1'b0)); tick();
    cmp("n10_force_dout", dout1, 8'hFF); cmp("n10_force_err", err1, 1);
    force1 = 1'b0; sel1 = 4'd4; q1.push_back(mk(1, 4, 1'b0, 1'b0)); tick();
    mode1 = 1'b1; tick();
    cmp("n10_idle_vld", vld1, 0);
    start1 = 1'b1; push_scan(1, 1'b0, 1'b0); tick(); start1 = 1'b0;
    for (int k = 0; k < N1; k++) tick();
    cmp("n10_last_ch", ch1, 9); cmp("n10_last", last1, 1); cmp("n10_busy", busy1, 0);
    tick();
    cmp("n10_stop_vld", vld1, 0);
    tick();
    cmp("n10_no_wrap", vld1, 0);
    drain(1, 5);

    cmp("final_q0", q0.size(), 0);
    cmp("final_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
